// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C transaction arbiter slice.
//  arb_state_t : arbiter FSM states
//  I2C_ADDR_W  : 7-bit I2C target address width
//  I2C_DATA_W  : I2C data byte width
package i2c_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//  req      in  N   request vector
//  last_gnt in  IW  index of the previously granted requester
//  gnt      out N   one-hot grant (all zero when no request)
//  gnt_idx  out IW  index of the granted requester (0 when no request)
// The search starts at last_gnt+1 and wraps: the request vector is doubled and
// shifted so the first set bit of the low half is the winner.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_gnt,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW:0]  shift;
  logic [N-1:0] rot;
  logic         found;
  int           pos;

  always_comb begin
    shift   = {1'b0, last_gnt} + {{IW{1'b0}}, 1'b1};
    rot     = N'({req, req} >> shift);
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        // shift + i is at most 2N-1, so one subtraction folds it back into range
        pos = int'(shift) + i;
        if (pos >= int'(N)) begin
          pos = pos - int'(N);
        end
        gnt_idx      = IW'(pos);
        gnt[gnt_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master engine among N_CLIENTS requesters.
// Round-robin picks a pending client, latches its addr/rw/wdata, pulses m_start,
// waits for m_done or a timeout and answers the client with a done or err pulse.
//  CLK, RST         clock (rising edge), asynchronous active-high reset
//  cli_req          per-client request, held until done/err
//  cli_addr/rw/wdata flattened per-client transaction fields
//  cli_gnt          one-hot grant, high from ISSUE through RESP
//  cli_done/cli_err one-cycle completion / timeout pulse to the granted client
//  cli_rdata        read byte, captured on m_done for reads and held
//  m_start          one-cycle start pulse to the master
//  m_addr/rw/wdata  latched fields, stable from ISSUE through RESP
//  m_done, m_rdata  master completion pulse and read data
// All outputs are registered.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned N_CLIENTS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [N_CLIENTS-1:0]            cli_req,
  input  logic [N_CLIENTS*I2C_ADDR_W-1:0] cli_addr,
  input  logic [N_CLIENTS-1:0]            cli_rw,
  input  logic [N_CLIENTS*I2C_DATA_W-1:0] cli_wdata,
  output logic [N_CLIENTS-1:0]            cli_gnt,
  output logic [N_CLIENTS-1:0]            cli_done,
  output logic [N_CLIENTS-1:0]            cli_err,
  output logic [I2C_DATA_W-1:0]           cli_rdata,
  output logic                            m_start,
  output logic [I2C_ADDR_W-1:0]           m_addr,
  output logic                            m_rw,
  output logic [I2C_DATA_W-1:0]           m_wdata,
  input  logic                            m_done,
  input  logic [I2C_DATA_W-1:0]           m_rdata
);

  localparam int unsigned IW = $clog2(N_CLIENTS);

  arb_state_t          state_q;
  logic [IW-1:0]       last_gnt_q;
  logic [IW-1:0]       gidx_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [N_CLIENTS-1:0] arb_gnt;
  logic [IW-1:0]        arb_idx;

  rr_arbiter #(
    .N (N_CLIENTS)
  ) u_rr_arbiter (
    .req      (cli_req),
    .last_gnt (last_gnt_q),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= IW'(N_CLIENTS - 1);
      gidx_q     <= '0;
      cnt_q      <= '0;
      cli_gnt    <= '0;
      cli_done   <= '0;
      cli_err    <= '0;
      cli_rdata  <= '0;
      m_start    <= 1'b0;
      m_addr     <= '0;
      m_rw       <= 1'b0;
      m_wdata    <= '0;
    end else begin
      // Pulses default low; the state that raises them overrides below.
      m_start  <= 1'b0;
      cli_done <= '0;
      cli_err  <= '0;
      unique case (state_q)
        ARB_IDLE: begin
          if (|cli_req) begin
            m_addr  <= cli_addr[I2C_ADDR_W*arb_idx +: I2C_ADDR_W];
            m_rw    <= cli_rw[arb_idx];
            m_wdata <= cli_wdata[I2C_DATA_W*arb_idx +: I2C_DATA_W];
            cli_gnt <= arb_gnt;
            gidx_q  <= arb_idx;
            m_start <= 1'b1;
            state_q <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          // m_done is deliberately ignored here
          cnt_q   <= '0;
          state_q <= ARB_WAIT;
        end
        ARB_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // m_done takes priority over a timeout in the same cycle
          if (m_done) begin
            if (m_rw) begin
              cli_rdata <= m_rdata;
            end
            cli_done[gidx_q] <= 1'b1;
            state_q          <= ARB_RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cli_err[gidx_q] <= 1'b1;
            state_q         <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          last_gnt_q <= gidx_q;
          cli_gnt    <= '0;
          state_q    <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule
